// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, issue-stage state encoding and
// the default datapath width. Imported by the issue stage and by the ALU.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int OP_W       = 5;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_NOP = 5'h00;
  localparam alu_op_t OP_ADD = 5'h01;
  localparam alu_op_t OP_SUB = 5'h02;
  localparam alu_op_t OP_AND = 5'h03;
  localparam alu_op_t OP_OR  = 5'h04;
  localparam alu_op_t OP_XOR = 5'h05;
  localparam alu_op_t OP_NOR = 5'h06;
  localparam alu_op_t OP_MAX = 5'h06;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } issue_state_e;

  // Anything above the highest defined opcode is rejected by the issue stage.
  function automatic logic is_legal_op(input alu_op_t op);
    return (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational source read ports, one
// combinational debug read port and one synchronous write port. Register 0
// always reads as zero and is never written.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_raAddr,
  output logic [DATA_W-1:0] o_raData,
  input  logic [ADDR_W-1:0] i_rbAddr,
  output logic [DATA_W-1:0] o_rbData,
  input  logic [ADDR_W-1:0] i_dbgAddr,
  output logic [DATA_W-1:0] o_dbgData,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wAddr,
  input  logic [DATA_W-1:0] i_wData
);

  logic [DATA_W-1:0] r_mem [REG_N];

  // Synchronous clear of every register; writes to index 0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_wAddr != '0)) begin
      r_mem[i_wAddr] <= i_wData;
    end
  end

  assign o_raData  = (i_raAddr  == '0) ? '0 : r_mem[i_raAddr];
  assign o_rbData  = (i_rbAddr  == '0) ? '0 : r_mem[i_rbAddr];
  assign o_dbgData = (i_dbgAddr == '0) ? '0 : r_mem[i_dbgAddr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand-issue and writeback stage in front of a clocked ALU. Accepts one
// register-to-register command at a time, presents its operands to the ALU,
// collects the registered ALU result one cycle later and writes it back.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_N  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [ADDR_W-1:0] cmd_rt,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  issue_state_e      r_state;
  issue_state_e      w_nextState;

  logic [DATA_W-1:0] r_aluA;
  logic [DATA_W-1:0] r_aluB;
  alu_op_t           r_aluOp;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_result;
  logic              r_done;
  logic              r_err;

  logic              w_ready;
  logic              w_wbEn;
  logic              w_accept;
  logic              w_acceptLegal;
  logic              w_acceptIllegal;
  logic [DATA_W-1:0] w_rsData;
  logic [DATA_W-1:0] w_rtData;

  assign w_accept        = cmd_valid & w_ready;
  assign w_acceptLegal   = w_accept &  is_legal_op(cmd_op);
  assign w_acceptIllegal = w_accept & ~is_legal_op(cmd_op);

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_raAddr  (cmd_rs),
    .o_raData  (w_rsData),
    .i_rbAddr  (cmd_rt),
    .o_rbData  (w_rtData),
    .i_dbgAddr (dbg_addr),
    .o_dbgData (dbg_data),
    .i_we      (w_wbEn),
    .i_wAddr   (r_rd),
    .i_wData   (alu_out)
  );

  // State register; reset also aborts any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Legal commands walk IDLE -> EXEC -> WB -> IDLE; illegal ones never leave IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_acceptLegal) w_nextState = ST_EXEC;
      ST_EXEC: w_nextState = ST_WB;
      ST_WB:   w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Decode the state into the handshake and writeback enables.
  always_comb begin
    w_ready = 1'b0;
    w_wbEn  = 1'b0;
    case (r_state)
      ST_IDLE: w_ready = ~rst;
      ST_WB:   w_wbEn  = 1'b1;
      default: ;
    endcase
  end

  // Operand/opcode launch at accept, completion status at writeback or rejection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluA   <= '0;
      r_aluB   <= '0;
      r_aluOp  <= OP_NOP;
      r_rd     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_acceptLegal) begin
        r_aluA  <= w_rsData;
        r_aluB  <= w_rtData;
        r_aluOp <= cmd_op;
        r_rd    <= cmd_rd;
      end else if (w_acceptIllegal) begin
        r_result <= '0;
        r_done   <= 1'b1;
        r_err    <= 1'b1;
      end
      if (w_wbEn) begin
        r_result <= alu_out;
        r_done   <= 1'b1;
        r_aluOp  <= OP_NOP;
      end
    end
  end

  assign cmd_ready = w_ready;
  assign alu_a     = r_aluA;
  assign alu_b     = r_aluB;
  assign alu_op    = r_aluOp;
  assign result    = r_result;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl. The bench plays the part of the
// clocked ALU and can override its output to seed registers.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [4:0]  cmd_rs;
  logic [4:0]  cmd_rt;
  logic [4:0]  cmd_rd;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_out;
  logic        done;
  logic        err;
  logic [31:0] result;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int nChecks = 0;
  int nPass   = 0;

  logic        aluForce    = 1'b0;
  logic [31:0] aluForceVal = '0;

  logic [31:0] obsA, obsB, obsResult;
  logic [4:0]  obsOp, obsOpAfter;
  logic        obsEarly, obsDone, obsErr;

  alu_issue_ctrl #(.DATA_W(32), .REG_N(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .done(done), .err(err), .result(result),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Stand-in for the registered ALU, with an override used to seed registers.
  always @(posedge clk) begin
    if (aluForce) alu_out <= aluForceVal;
    else begin
      case (alu_op)
        OP_ADD:  alu_out <= alu_a + alu_b;
        OP_SUB:  alu_out <= alu_a - alu_b;
        OP_AND:  alu_out <= alu_a & alu_b;
        OP_OR:   alu_out <= alu_a | alu_b;
        OP_XOR:  alu_out <= alu_a ^ alu_b;
        OP_NOR:  alu_out <= ~(alu_a | alu_b);
        default: alu_out <= 32'h0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readDbg(input logic [4:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // Issues one legal command and records what is seen in cycles 1..3 after accept.
  task automatic runCmd(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    for (int k = 0; k < 10 && !cmd_ready; k++) tick();
    if (!cmd_ready) begin
      nChecks++;
      $display("[TB] FAIL ready_timeout: cmd_ready=%b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    tick();
    cmd_valid = 1'b0;
    obsA = alu_a; obsB = alu_b; obsOp = alu_op; obsEarly = done;
    tick();
    obsEarly = obsEarly | done;
    tick();
    obsDone = done; obsErr = err; obsResult = result; obsOpAfter = alu_op;
  endtask

  task automatic seed(input logic [4:0] rd, input logic [31:0] v);
    aluForce = 1'b1; aluForceVal = v;
    runCmd(OP_ADD, 5'd0, 5'd0, rd);
    aluForce = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int bad;
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd3; dbg_addr = '0;
    tick(); tick(); tick();
    nChecks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL rst_ready: got %b expected 0", cmd_ready); else nPass++;
    nChecks++; if (done !== 1'b0) $display("[TB] FAIL rst_done: got %b expected 0", done); else nPass++;
    nChecks++; if (err !== 1'b0) $display("[TB] FAIL rst_err: got %b expected 0", err); else nPass++;
    nChecks++; if (alu_op !== 5'h00) $display("[TB] FAIL rst_aluop: got %h expected 00", alu_op); else nPass++;
    nChecks++; if (result !== 32'h0) $display("[TB] FAIL rst_result: got %h expected 0", result); else nPass++;
    nChecks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) $display("[TB] FAIL rst_operands: got %h/%h expected 0/0", alu_a, alu_b); else nPass++;
    cmd_valid = 1'b0;
    rst = 1'b0;
    tick();
    nChecks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL release_ready: got %b expected 1", cmd_ready); else nPass++;
    nChecks++; if (done !== 1'b0) $display("[TB] FAIL release_done: got %b expected 0", done); else nPass++;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      readDbg(i[4:0], d);
      if (d !== 32'h0) bad++;
    end
    nChecks++; if (bad != 0) $display("[TB] FAIL rst_regs_zero: got %0d nonzero registers expected 0", bad); else nPass++;
  endtask

  task automatic test_arith();
    logic [31:0] d;
    seed(5'd1, 32'h0000_0005);
    seed(5'd2, 32'h0000_0003);
    runCmd(OP_ADD, 5'd1, 5'd2, 5'd3);
    nChecks++; if (obsA !== 32'h5 || obsB !== 32'h3) $display("[TB] FAIL add_operands: got %h/%h expected 5/3", obsA, obsB); else nPass++;
    nChecks++; if (obsOp !== OP_ADD) $display("[TB] FAIL add_aluop: got %h expected 01", obsOp); else nPass++;
    nChecks++; if (obsEarly !== 1'b0) $display("[TB] FAIL add_early_done: got %b expected 0", obsEarly); else nPass++;
    nChecks++; if (obsDone !== 1'b1 || obsErr !== 1'b0) $display("[TB] FAIL add_done_cycle3: got done=%b err=%b expected 1/0", obsDone, obsErr); else nPass++;
    nChecks++; if (obsResult !== 32'h8) $display("[TB] FAIL add_result: got %h expected 00000008", obsResult); else nPass++;
    nChecks++; if (obsOpAfter !== OP_NOP) $display("[TB] FAIL add_op_nop_after: got %h expected 00", obsOpAfter); else nPass++;
    readDbg(5'd3, d);
    nChecks++; if (d !== 32'h8) $display("[TB] FAIL add_dbg_r3: got %h expected 00000008", d); else nPass++;
    tick();
    nChecks++; if (done !== 1'b0) $display("[TB] FAIL done_one_cycle: got %b expected 0", done); else nPass++;
    runCmd(OP_SUB, 5'd1, 5'd2, 5'd4);
    nChecks++; if (obsResult !== 32'h2) $display("[TB] FAIL sub_result: got %h expected 00000002", obsResult); else nPass++;
    runCmd(OP_SUB, 5'd2, 5'd1, 5'd5);
    nChecks++; if (obsResult !== 32'hFFFF_FFFE) $display("[TB] FAIL sub_neg_result: got %h expected fffffffe", obsResult); else nPass++;
    readDbg(5'd5, d);
    nChecks++; if (d !== 32'hFFFF_FFFE) $display("[TB] FAIL sub_neg_dbg_r5: got %h expected fffffffe", d); else nPass++;
  endtask

  task automatic test_logic();
    logic [31:0] d;
    seed(5'd1, 32'hF0F0_F0F0);
    seed(5'd2, 32'hFF00_FF00);
    runCmd(OP_AND, 5'd1, 5'd2, 5'd6);
    nChecks++; if (obsResult !== 32'hF000_F000) $display("[TB] FAIL and_result: got %h expected f000f000", obsResult); else nPass++;
    runCmd(OP_OR, 5'd1, 5'd2, 5'd7);
    nChecks++; if (obsResult !== 32'hFFF0_FFF0) $display("[TB] FAIL or_result: got %h expected fff0fff0", obsResult); else nPass++;
    runCmd(OP_XOR, 5'd1, 5'd2, 5'd8);
    nChecks++; if (obsResult !== 32'h0FF0_0FF0) $display("[TB] FAIL xor_result: got %h expected 0ff00ff0", obsResult); else nPass++;
    runCmd(OP_NOR, 5'd1, 5'd2, 5'd9);
    nChecks++; if (obsResult !== 32'h000F_000F) $display("[TB] FAIL nor_result: got %h expected 000f000f", obsResult); else nPass++;
    readDbg(5'd6, d);
    nChecks++; if (d !== 32'hF000_F000) $display("[TB] FAIL and_dbg_r6: got %h expected f000f000", d); else nPass++;
  endtask

  task automatic test_wrap_and_r0();
    logic [31:0] d;
    seed(5'd10, 32'hFFFF_FFFF);
    seed(5'd11, 32'h0000_0001);
    runCmd(OP_ADD, 5'd10, 5'd11, 5'd12);
    nChecks++; if (obsResult !== 32'h0 || obsDone !== 1'b1) $display("[TB] FAIL add_wrap: got %h done=%b expected 0 done=1", obsResult, obsDone); else nPass++;
    runCmd(OP_ADD, 5'd11, 5'd11, 5'd11);
    nChecks++; if (obsResult !== 32'h2) $display("[TB] FAIL same_src_dst: got %h expected 00000002", obsResult); else nPass++;
    runCmd(OP_ADD, 5'd1, 5'd2, 5'd0);
    nChecks++; if (obsResult !== 32'hEFF1_EFF0 || obsDone !== 1'b1) $display("[TB] FAIL rd0_result: got %h done=%b expected eff1eff0 done=1", obsResult, obsDone); else nPass++;
    readDbg(5'd0, d);
    nChecks++; if (d !== 32'h0) $display("[TB] FAIL rd0_dbg: got %h expected 0", d); else nPass++;
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    for (int k = 0; k < 10 && !cmd_ready; k++) tick();
    cmd_valid = 1'b1; cmd_op = 5'h1F; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd13;
    tick();
    cmd_valid = 1'b0;
    nChecks++; if (done !== 1'b1 || err !== 1'b1) $display("[TB] FAIL illegal_flags: got done=%b err=%b expected 1/1", done, err); else nPass++;
    nChecks++; if (result !== 32'h0) $display("[TB] FAIL illegal_result: got %h expected 0", result); else nPass++;
    nChecks++; if (alu_op !== 5'h00) $display("[TB] FAIL illegal_aluop: got %h expected 00", alu_op); else nPass++;
    nChecks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL illegal_stay_idle: got %b expected 1", cmd_ready); else nPass++;
    tick();
    nChecks++; if (done !== 1'b0 || err !== 1'b0) $display("[TB] FAIL illegal_pulse_width: got done=%b err=%b expected 0/0", done, err); else nPass++;
    readDbg(5'd13, d);
    nChecks++; if (d !== 32'h0) $display("[TB] FAIL illegal_no_write: got %h expected 0", d); else nPass++;
    readDbg(5'd1, d);
    nChecks++; if (d !== 32'hF0F0_F0F0) $display("[TB] FAIL illegal_r1_kept: got %h expected f0f0f0f0", d); else nPass++;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  bOp [3];
    logic [4:0]  bRs [3];
    logic [4:0]  bRd [3];
    logic [31:0] expRes [3];
    int accCyc [3];
    int doneCyc [3];
    logic [31:0] doneRes [3];
    int na, nd;
    logic acc;
    logic [31:0] d;
    bOp = '{OP_ADD, OP_SUB, OP_XOR};
    bRs = '{5'd1, 5'd1, 5'd14};
    bRd = '{5'd14, 5'd15, 5'd16};
    expRes = '{32'hEFF1_EFF0, 32'hF1EF_F1F0, 32'h1F01_1F00};
    for (int i = 0; i < 3; i++) begin accCyc[i] = -1; doneCyc[i] = -1; doneRes[i] = '0; end
    na = 0; nd = 0;
    for (int k = 0; k < 10 && !cmd_ready; k++) tick();
    cmd_valid = 1'b1; cmd_op = bOp[0]; cmd_rs = bRs[0]; cmd_rt = (bOp[0] == OP_XOR) ? 5'd1 : 5'd2; cmd_rd = bRd[0];
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done === 1'b1 && nd < 3) begin doneCyc[nd] = cyc; doneRes[nd] = result; nd++; end
      acc = cmd_valid & cmd_ready;
      if (acc && na < 3) begin accCyc[na] = cyc; na++; end
      tick();
      if (acc) begin
        if (na < 3) begin
          cmd_op = bOp[na]; cmd_rs = bRs[na]; cmd_rt = (bOp[na] == OP_XOR) ? 5'd1 : 5'd2; cmd_rd = bRd[na];
        end else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nChecks++; if (accCyc[i] != 3 * i) $display("[TB] FAIL b2b_accept_%0d: got cycle %0d expected %0d", i, accCyc[i], 3 * i); else nPass++;
      nChecks++; if (doneCyc[i] != 3 * i + 3) $display("[TB] FAIL b2b_done_%0d: got cycle %0d expected %0d", i, doneCyc[i], 3 * i + 3); else nPass++;
      nChecks++; if (doneRes[i] !== expRes[i]) $display("[TB] FAIL b2b_result_%0d: got %h expected %h", i, doneRes[i], expRes[i]); else nPass++;
    end
    readDbg(5'd16, d);
    nChecks++; if (d !== 32'h1F01_1F00) $display("[TB] FAIL b2b_dbg_r16: got %h expected 1f011f00", d); else nPass++;
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] d;
    logic sawDone;
    for (int k = 0; k < 10 && !cmd_ready; k++) tick();
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd17;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    nChecks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL mid_rst_ready: got %b expected 0", cmd_ready); else nPass++;
    tick();
    rst = 1'b0;
    sawDone = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sawDone = sawDone | (done === 1'b1);
      tick();
    end
    nChecks++; if (sawDone !== 1'b0) $display("[TB] FAIL mid_rst_no_done: got %b expected 0", sawDone); else nPass++;
    readDbg(5'd17, d);
    nChecks++; if (d !== 32'h0) $display("[TB] FAIL mid_rst_rd_unchanged: got %h expected 0", d); else nPass++;
    readDbg(5'd1, d);
    nChecks++; if (d !== 32'h0) $display("[TB] FAIL mid_rst_regs_cleared: got %h expected 0", d); else nPass++;
    nChecks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL mid_rst_ready_after: got %b expected 1", cmd_ready); else nPass++;
    nChecks++; if (alu_op !== 5'h00) $display("[TB] FAIL mid_rst_aluop: got %h expected 00", alu_op); else nPass++;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; dbg_addr = '0;
    test_reset();
    test_arith();
    test_logic();
    test_wrap_and_r0();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Operand-issue and writeback stage directly upstream of the clocked ALU.
- Accepts register-to-register ALU commands over a valid/ready handshake and reads both source operands from an internal register file.
- Drives the ALU's A, B and op inputs, waits for the ALU's registered result, writes it to the destination register and reports completion.
- Serialises one command at a time, so no hazard or bypass logic is needed.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- REG_N, 32, number of architectural registers; register 0 reads as 0.
- ADDR_W, 5, register index width; equals clog2(REG_N).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  5  ALU opcode (NOP=0x00, ADD=0x01, SUB=0x02, AND=0x03, OR=0x04, XOR=0x05, NOR=0x06).
- cmd_rs  in  ADDR_W  source register for A.
- cmd_rt  in  ADDR_W  source register for B.
- cmd_rd  in  ADDR_W  destination register.
- alu_a  out  DATA_W  to ALU_A.
- alu_b  out  DATA_W  to ALU_B.
- alu_op  out  5  to ALU_OP.
- alu_out  in  DATA_W  from ALU_OUT; the ALU registers it on clk.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done when the opcode was illegal.
- result  out  DATA_W  value written (or that would have been written); held until the next done.
- dbg_addr  in  ADDR_W  debug read index.
- dbg_data  out  DATA_W  combinational read of register dbg_addr (0 for index 0).

Behaviour:
- Reset:
  - clk is the only clock; rst is synchronous, active-high.
  - Next edge with rst=1 sets state=IDLE, alu_a=0, alu_b=0, alu_op=NOP, done=0, err=0, result=0, and clears all registers.
  - Reset mid-command aborts it: no writeback, no done.
- States: IDLE, EXEC, WB.
- cmd_ready is combinational: 1 iff state==IDLE and rst==0.
- Accept: cmd_valid & cmd_ready at an edge. Capture rd and op.
  - Legal op (<=0x06): alu_a<=rf[rs], alu_b<=rf[rt], alu_op<=op; go to EXEC.
  - Illegal op (>0x06): alu_op stays NOP; next cycle done=1, err=1, result=0; no writeback; stay IDLE.
- EXEC (1 cycle): alu_a/alu_b/alu_op stay stable; the ALU samples them at the end of this cycle. Go to WB.
- WB (1 cycle): alu_out is valid. At the end of the cycle:
  - rf[rd]<=alu_out, unless rd==0, which is discarded.
  - result<=alu_out, done<=1.
  - alu_op<=NOP; go to IDLE.
- Latency: accept edge at cycle 0; done is high in cycle 3.
- Throughput: 1 command per 3 cycles. A new command may be accepted in the same cycle done is high.
- Register 0 reads as 0 on all read paths, even while rd==0 is being written.
- Source reads happen at the accept edge. rs==rt and rd==rs are legal; the source value is the pre-write value.
- Arithmetic: ALU defines it; ADD/SUB wrap modulo 2^DATA_W, with no overflow flag.
- done and err are registered, high exactly one cycle per command.
- cmd_* are ignored when cmd_ready=0.
- dbg port has no side effects; it reflects a write from the cycle after the write edge.

Decomposition:
- Shared package alu_pkg:
  - 5-bit opcode constants (NOP..NOR) and OP_MAX=0x06.
  - State enum encoding (IDLE/EXEC/WB).
  - DATA_W default.
  - Both this block and the ALU import the opcodes from it.
- One sub-module, regfile_2r1w:
  - REG_N x DATA_W, two combinational read ports plus dbg read, one synchronous write port.
  - Register 0 hardwired to zero; synchronous clear on rst.

Test Plan:
- Reset then dbg read of all 32 registers -> all 0. Hold cmd_valid during rst -> cmd_ready=0, no done.
- Seed r1=0x0000_0005, r2=0x0000_0003 (via ADD from r0 plus prior results or a bench backdoor). Then ADD rd=3 -> done in cycle 3 with result=0x8; dbg r3=0x8. SUB rd=4 -> 0x2; SUB r2-r1 -> 0xFFFF_FFFE.
- Logic ops with r1=0xF0F0_F0F0, r2=0xFF00_FF00:
  - AND -> 0xF000_F000.
  - OR -> 0xFFF0_FFF0.
  - XOR -> 0x0FF0_0FF0.
  - NOR -> 0x000F_000F.
- ADD 0xFFFF_FFFF+1 -> 0x0 (wrap). Write to rd=0 -> done with result, dbg r0 still 0.
- Illegal op 0x1F -> done=1 and err=1 one cycle after accept, result=0, no register changes, alu_op stays 0x00.
- Back-to-back: cmd_valid held high with 3 commands -> accepts at cycles 0, 3, 6. Then assert rst while in EXEC -> no done, dbg rd unchanged (0), cmd_ready=1 after reset release.
